uart_rx_serial: RTL and testbench
=================================

UART_RX_SERIAL -- requirements
Module: uart_rx_serial

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 16000000, giving the i_Clock frequency in Hz.
REQ-002 SHALL use one clock; reset is asynchronous and active-high.
REQ-003 i_Clock  in  1  system clock; all state changes on its rising edge.
REQ-004 i_Reset  in  1  asynchronous, active-high reset.
REQ-005 i_Baudrate  in  32  requested bit rate in bits/s, same encoding as the uart_tx baudrate input.
REQ-006 i_Rx_Serial  in  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-007 o_Rx_DV  out  1  one-cycle pulse when o_Rx_Byte is updated with a good frame.
REQ-008 o_Rx_Byte  out  8  last correctly framed byte, held until the next good frame.
REQ-009 o_Rx_Frame_Err  out  1  one-cycle pulse when a stop bit samples low.
REQ-010 o_Rx_Active  out  1  high while a frame is in START, DATA or STOP.
REQ-011 o_Rx_Ready  out  1  high when the bit divisor is valid and reception is enabled.

Function
REQ-012 SHALL pass i_Rx_Serial through a 2-flop synchronizer (rx_s) with both flops resetting to 1; all decisions use rx_s.
REQ-013 SHALL latch i_Baudrate and compute CPB = floor(CLK_FREQ_HZ / baud) with a sequential restoring divider, one quotient bit per cycle, 32 cycles.
REQ-014 Division SHALL start on the first cycle after reset release and on any cycle where i_Baudrate differs from the latched value.
REQ-015 o_Rx_Ready SHALL be 0 while dividing; on completion, CPB is written and o_Rx_Ready goes 1 on the next cycle.
REQ-016 If the latched baud is 0, no division SHALL run and o_Rx_Ready SHALL stay 0.
REQ-017 If the computed CPB is below 4, it SHALL be clamped to 4.
REQ-018 A baud change mid-frame SHALL abort the frame: FSM to IDLE, no o_Rx_DV, no o_Rx_Frame_Err.
REQ-019 The FSM SHALL have states IDLE, START, DATA, STOP and BREAK, with a cycle counter and a 3-bit bit index.
REQ-020 In IDLE with o_Rx_Ready=1, rx_s=0 SHALL move to START and clear the counter; the frame origin T0 is that rx_s-low cycle.
REQ-021 Sample points SHALL be T0 + HALF + k*CPB for k=0..9, where HALF = CPB>>1: k=0 is start, k=1..8 are data, k=9 is stop.
REQ-022 START at k=0: rx_s=1 is a glitch and SHALL return to IDLE silently; rx_s=0 SHALL go to DATA.
REQ-023 DATA SHALL shift rx_s in LSB first, with the first data bit ending in bit 0, and SHALL go to STOP after k=8.
REQ-024 STOP at k=9 with rx_s=1 SHALL load o_Rx_Byte, pulse o_Rx_DV on the following cycle, and return to IDLE at once so a back-to-back start is caught.
REQ-025 STOP at k=9 with rx_s=0 SHALL pulse o_Rx_Frame_Err on the following cycle, leave o_Rx_Byte unchanged, and go to BREAK.
REQ-026 BREAK SHALL go to IDLE on the first cycle rx_s=1, which is not a start.
REQ-027 o_Rx_DV and o_Rx_Frame_Err SHALL never be high in the same cycle and SHALL never stay high 2 consecutive cycles.
REQ-028 The counter SHALL be wide enough for CPB up to 2^32-1 and SHALL never wrap mid-bit.

Reset
REQ-029 While i_Reset=1, SHALL force: o_Rx_DV=0, o_Rx_Frame_Err=0, o_Rx_Active=0, o_Rx_Ready=0, o_Rx_Byte=8'h00, FSM=IDLE, synchronizer=1, counter=0, CPB=0, latched baud=0.
REQ-030 Reset asserted mid-frame SHALL drop the frame with no output pulse; after release, division restarts per REQ-014.

Verification
REQ-031 Reset, i_Baudrate=115200 -> o_Rx_Ready=0 for 32 cycles, then 1 with CPB=138; send 0xA5 at 138 clk/bit -> one o_Rx_DV pulse, o_Rx_Byte=8'hA5, DV at T0+69+9*138+1.
REQ-032 Drive i_Rx_Serial low for 30 cycles, then high -> no o_Rx_DV, no o_Rx_Frame_Err; o_Rx_Active high for fewer than 70 cycles.
REQ-033 Frame 0x3C with stop bit 0, line held low 3000 cycles, then 0x5A sent normally -> one o_Rx_Frame_Err pulse, o_Rx_Byte stays 00, then DV with 8'h5A.
REQ-034 Back-to-back 0x00 then 0xFF, one stop bit each, no idle gap -> two DV pulses with 8'h00 then 8'hFF.
REQ-035 Change i_Baudrate to 9600 at data bit 4 of a frame -> no pulse, o_Rx_Ready=0 for 32 cycles, CPB=1666; a 9600-baud 0x81 is then received correctly.
REQ-036 Assert i_Reset for 1 cycle at data bit 6 -> all outputs at reset values at once, no DV for that frame; the next frame is received after the divide completes.

Source files
------------

// File: rtl/uart_rx_serial.sv
// 8N1 UART receiver with run-time baud; bit period = floor(CLK_FREQ_HZ/baud) from a 32-cycle serial divider.
// Latency: byte/err pulse one cycle after the mid-stop sample; backpressure: none, the line cannot be stalled.
module uart_rx_serial #(
    parameter int unsigned CLK_FREQ_HZ = 16000000
) (
    input  logic        i_Clock,
    input  logic        i_Reset,
    input  logic [31:0] i_Baudrate,
    input  logic        i_Rx_Serial,
    output logic        o_Rx_DV,
    output logic [7:0]  o_Rx_Byte,
    output logic        o_Rx_Frame_Err,
    output logic        o_Rx_Active,
    output logic        o_Rx_Ready
);

    localparam logic [31:0] DIVIDEND = CLK_FREQ_HZ;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

    logic        rx_meta, rx_s;
    logic        init_q;
    logic [31:0] baud_q;
    logic        div_busy;
    logic [4:0]  div_cnt;
    logic [31:0] div_rem, div_dvd, div_quot;
    logic [31:0] cpb;
    logic        ready_q;

    logic        start_div;
    logic [32:0] rem_sh;
    logic        ge;
    logic [31:0] rem_nx, quot_nx, half;

    state_t      state;
    logic [31:0] cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;

    assign start_div = init_q | (i_Baudrate != baud_q);
    assign rem_sh    = {div_rem, div_dvd[31]};
    assign ge        = rem_sh >= {1'b0, baud_q};
    assign rem_nx    = ge ? (rem_sh[31:0] - baud_q) : rem_sh[31:0];
    assign quot_nx   = {div_quot[30:0], ge};
    assign half      = {1'b0, cpb[31:1]};
    assign o_Rx_Ready = ready_q;

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_Rx_Serial;
            rx_s    <= rx_meta;
        end
    end

    // Restoring divider: one quotient bit per cycle, restarted by any baud change.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            init_q   <= 1'b1;
            baud_q   <= '0;
            div_busy <= 1'b0;
            div_cnt  <= '0;
            div_rem  <= '0;
            div_dvd  <= '0;
            div_quot <= '0;
            cpb      <= '0;
            ready_q  <= 1'b0;
        end else begin
            init_q <= 1'b0;
            if (start_div) begin
                baud_q   <= i_Baudrate;
                ready_q  <= 1'b0;
                div_busy <= (i_Baudrate != 32'd0);
                div_cnt  <= '0;
                div_rem  <= '0;
                div_dvd  <= DIVIDEND;
                div_quot <= '0;
            end else if (div_busy) begin
                div_rem  <= rem_nx;
                div_dvd  <= {div_dvd[30:0], 1'b0};
                div_quot <= quot_nx;
                div_cnt  <= div_cnt + 5'd1;
                if (div_cnt == 5'd31) begin
                    div_busy <= 1'b0;
                    cpb      <= (quot_nx < 32'd4) ? 32'd4 : quot_nx;
                    ready_q  <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state          <= S_IDLE;
            cnt            <= '0;
            bit_idx        <= '0;
            shreg          <= '0;
            o_Rx_Byte      <= 8'h00;
            o_Rx_DV        <= 1'b0;
            o_Rx_Frame_Err <= 1'b0;
            o_Rx_Active    <= 1'b0;
        end else begin
            o_Rx_DV        <= 1'b0;
            o_Rx_Frame_Err <= 1'b0;
            if (start_div) begin
                state       <= S_IDLE;
                cnt         <= '0;
                o_Rx_Active <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (ready_q && !rx_s) begin
                            state       <= S_START;
                            cnt         <= '0;
                            o_Rx_Active <= 1'b1;
                        end
                    end
                    S_START: begin
                        if (cnt == half - 32'd1) begin
                            cnt <= '0;
                            if (rx_s) begin
                                state       <= S_IDLE;
                                o_Rx_Active <= 1'b0;
                            end else begin
                                state   <= S_DATA;
                                bit_idx <= '0;
                            end
                        end else begin
                            cnt <= cnt + 32'd1;
                        end
                    end
                    S_DATA: begin
                        if (cnt == cpb - 32'd1) begin
                            cnt     <= '0;
                            shreg   <= {rx_s, shreg[7:1]};
                            bit_idx <= bit_idx + 3'd1;
                            if (bit_idx == 3'd7) state <= S_STOP;
                        end else begin
                            cnt <= cnt + 32'd1;
                        end
                    end
                    S_STOP: begin
                        if (cnt == cpb - 32'd1) begin
                            cnt         <= '0;
                            o_Rx_Active <= 1'b0;
                            if (rx_s) begin
                                o_Rx_Byte <= shreg;
                                o_Rx_DV   <= 1'b1;
                                state     <= S_IDLE;
                            end else begin
                                o_Rx_Frame_Err <= 1'b1;
                                state          <= S_BREAK;
                            end
                        end else begin
                            cnt <= cnt + 32'd1;
                        end
                    end
                    S_BREAK: begin
                        if (rx_s) state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_serial.sv
// Scoreboarded bench for uart_rx_serial: directed frames, glitch, break, back-to-back, baud change, reset mid-frame.
module tb_uart_rx_serial;

    logic        clk = 1'b0;
    logic        i_Reset;
    logic [31:0] i_Baudrate;
    logic        i_Rx_Serial;
    logic        o_Rx_DV;
    logic [7:0]  o_Rx_Byte;
    logic        o_Rx_Frame_Err;
    logic        o_Rx_Active;
    logic        o_Rx_Ready;

    uart_rx_serial dut (
        .i_Clock        (clk),
        .i_Reset        (i_Reset),
        .i_Baudrate     (i_Baudrate),
        .i_Rx_Serial    (i_Rx_Serial),
        .o_Rx_DV        (o_Rx_DV),
        .o_Rx_Byte      (o_Rx_Byte),
        .o_Rx_Frame_Err (o_Rx_Frame_Err),
        .o_Rx_Active    (o_Rx_Active),
        .o_Rx_Ready     (o_Rx_Ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       is_err;
        logic [7:0] byt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   dv_cyc = 0;
    int   dv_cnt = 0;
    int   err_cnt = 0;
    int   act_cnt = 0;
    int   start_cyc = 0;
    logic prev_pulse = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int got, input int lo, input int hi);
        checks++;
        if (got < lo || got > hi) begin
            failures++;
            $display("FAIL %s: got %0d expected range %0d..%0d", name, got, lo, hi);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every output pulse must match the head of the expectation queue.
    always @(negedge clk) begin
        exp_t e;
        if (o_Rx_Active) act_cnt++;
        if (o_Rx_DV || o_Rx_Frame_Err) begin
            chk("dv_err_exclusive", 32'(o_Rx_DV & o_Rx_Frame_Err), 32'd0);
            chk("pulse_one_cycle", 32'(prev_pulse), 32'd0);
            chk("pulse_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pulse_kind_err", 32'(o_Rx_Frame_Err), 32'(e.is_err));
                chk("rx_byte", 32'(o_Rx_Byte), 32'(e.byt));
            end
            if (o_Rx_DV) begin
                dv_cnt++;
                dv_cyc = cyc;
            end else begin
                err_cnt++;
            end
        end
        prev_pulse = o_Rx_DV || o_Rx_Frame_Err;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input int cpb, input int nbits);
        logic [9:0] v;
        v = {stop, b, 1'b0};
        start_cyc = cyc;
        for (int i = 0; i < nbits; i++) begin
            i_Rx_Serial = v[i];
            repeat (cpb) tick();
        end
    endtask

    task automatic wait_ready(output int lo);
        lo = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (o_Rx_Ready) break;
            lo++;
        end
        tick();
    endtask

    task automatic check_drained(input string name);
        for (int i = 0; i < 300 && exp_q.size() > 0; i++) tick();
        chk(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int lo;
        i_Reset     = 1'b1;
        i_Baudrate  = 32'd115200;
        i_Rx_Serial = 1'b1;
        repeat (4) tick();
        @(negedge clk);
        chk("rst_dv", 32'(o_Rx_DV), 32'd0);
        chk("rst_err", 32'(o_Rx_Frame_Err), 32'd0);
        chk("rst_active", 32'(o_Rx_Active), 32'd0);
        chk("rst_ready", 32'(o_Rx_Ready), 32'd0);
        chk("rst_byte", 32'(o_Rx_Byte), 32'd0);
        tick();
        i_Reset = 1'b0;

        // Divide 16 MHz / 115200 -> 138 clocks per bit.
        wait_ready(lo);
        chk_rng("ready_after_reset_lowcycles", lo, 32, 34);
        repeat (20) tick();
        exp_q.push_back('{1'b0, 8'hA5});
        send_frame(8'hA5, 1'b1, 138, 10);
        check_drained("a5_drained");
        chk("a5_dv_cycle", 32'(dv_cyc), 32'(start_cyc + 2 + 69 + 9 * 138 + 1));

        act_cnt = 0;
        i_Rx_Serial = 1'b0;
        repeat (30) tick();
        i_Rx_Serial = 1'b1;
        repeat (200) tick();
        chk_rng("glitch_active_cycles", act_cnt, 1, 69);

        exp_q.push_back('{1'b0, 8'h00});
        exp_q.push_back('{1'b0, 8'hFF});
        send_frame(8'h00, 1'b1, 138, 10);
        send_frame(8'hFF, 1'b1, 138, 10);
        check_drained("b2b_drained");

        // Baud change in the middle of data bit 4 must abort silently.
        send_frame(8'h55, 1'b1, 138, 5);
        i_Rx_Serial = 1'b1;
        repeat (69) tick();
        chk("active_before_abort", 32'(o_Rx_Active), 32'd1);
        i_Baudrate = 32'd9600;
        tick();
        wait_ready(lo);
        chk_rng("ready_after_baud_lowcycles", lo, 32, 34);
        chk("active_after_abort", 32'(o_Rx_Active), 32'd0);
        repeat (50) tick();
        exp_q.push_back('{1'b0, 8'h81});
        send_frame(8'h81, 1'b1, 1666, 10);
        check_drained("x81_drained");
        chk("x81_dv_cycle", 32'(dv_cyc), 32'(start_cyc + 2 + 833 + 9 * 1666 + 1));

        i_Baudrate = 32'd115200;
        tick();
        wait_ready(lo);
        repeat (20) tick();

        // Reset in the middle of data bit 6.
        send_frame(8'h33, 1'b1, 138, 7);
        i_Rx_Serial = 1'b0;
        repeat (69) tick();
        chk("active_before_reset", 32'(o_Rx_Active), 32'd1);
        i_Reset = 1'b1;
        #1;
        chk("midrst_active", 32'(o_Rx_Active), 32'd0);
        chk("midrst_ready", 32'(o_Rx_Ready), 32'd0);
        chk("midrst_byte", 32'(o_Rx_Byte), 32'd0);
        chk("midrst_dv", 32'(o_Rx_DV), 32'd0);
        tick();
        i_Reset = 1'b0;
        i_Rx_Serial = 1'b1;
        wait_ready(lo);
        chk_rng("ready_after_midrst_lowcycles", lo, 32, 34);
        repeat (20) tick();

        // Stop bit low followed by a long break, then a normal frame.
        exp_q.push_back('{1'b1, 8'h00});
        send_frame(8'h3C, 1'b0, 138, 10);
        repeat (3000) tick();
        i_Rx_Serial = 1'b1;
        repeat (300) tick();
        check_drained("break_drained");
        chk("byte_after_break", 32'(o_Rx_Byte), 32'h00);
        exp_q.push_back('{1'b0, 8'h5A});
        send_frame(8'h5A, 1'b1, 138, 10);
        check_drained("x5a_drained");

        repeat (200) tick();
        chk("total_dv", 32'(dv_cnt), 32'd5);
        chk("total_err", 32'(err_cnt), 32'd1);
        chk("final_byte", 32'(o_Rx_Byte), 32'h5A);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
